moore_seq_detector_param: RTL

Parametrised Moore-type serial sequence detector. The target pattern, pattern length and overlap mode are programmed at run time, so a single block covers any pattern up to MAX_LEN bits. It takes a 1-bit input stream qualified by a valid strobe, raises a registered one-cycle match flag, and keeps a saturating match counter. It replaces fixed-pattern, fixed-mode detector FSMs in the serial front end.

---
 rtl/moore_seq_detector_param.sv | 70 +++++++
 1 files changed

// File: rtl/moore_seq_detector_param.sv
// moore_seq_detector_param: run-time programmable Moore serial pattern detector with saturating match count
module moore_seq_detector_param #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W = 8,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat,
  output logic               cfg_err
);
  typedef enum logic [1:0] {UNCFG, HUNT, HIT} state_t;
  localparam logic [MAX_LEN:0] ONE = 1;
  state_t r_state;
  logic [MAX_LEN-1:0] r_hist, r_pat, w_hist_n, w_mask;
  logic [MAX_LEN:0] w_mask_ext;
  logic [LW-1:0] r_fill, r_len, w_fill_n;
  logic r_ovl, r_err, w_cfg_ok, w_hit;
  logic [CNT_W-1:0] r_cnt;
  assign w_cfg_ok = cfg_len != '0 && cfg_len <= LW'(MAX_LEN);
  assign w_hist_n = {r_hist[MAX_LEN-2:0], in};
  assign w_fill_n = r_fill == LW'(MAX_LEN) ? r_fill : r_fill + LW'(1);
  assign w_mask_ext = (ONE << r_len) - ONE;
  assign w_mask = w_mask_ext[MAX_LEN-1:0];
  assign w_hit = w_fill_n >= r_len && ((w_hist_n ^ r_pat) & w_mask) == '0;
  assign out = r_state == HIT;
  assign match_cnt = r_cnt;
  assign cnt_sat = &r_cnt;
  assign cfg_err = r_err;
  // Config capture, shift history, fill tracking, match counting and FSM state; cfg_load always wins over a data bit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= UNCFG;
      r_hist <= '0;
      r_pat <= '0;
      r_fill <= '0;
      r_len <= '0;
      r_ovl <= 1'b0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (cfg_load) begin
        if (w_cfg_ok) begin
          r_pat <= cfg_pattern;
          r_len <= cfg_len;
          r_ovl <= cfg_overlap;
          r_hist <= '0;
          r_fill <= '0;
          r_cnt <= '0;
          r_state <= HUNT;
        end else r_err <= 1'b1;
      end else if (r_state != UNCFG) begin
        if (in_valid) begin
          r_hist <= w_hist_n;
          r_fill <= w_hit && !r_ovl ? '0 : w_fill_n;
          r_state <= w_hit ? HIT : HUNT;
          if (w_hit && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
        end else r_state <= HUNT;
      end
    end
endmodule
